// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment write-side controller.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] nibble_t;

  // Requester identity; also the encoding of the arbiter's `last` pointer.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // A digit is lit unless it is blink-enabled and the blink phase is high.
  function automatic logic [NUM_DIGITS-1:0] digit_enables(
    input logic [NUM_DIGITS-1:0] mask,
    input logic                  phase
  );
    return ~(mask & {NUM_DIGITS{phase}});
  endfunction

endpackage : seg_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. `last` remembers the most recent winner so
// a requester that keeps req high cannot starve the other one.
module rr_arb2
  import seg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic hold,
  output logic gnt_a,
  output logic gnt_b
);

  req_id_t last_q;
  req_id_t last_d;

  // Grant decision; reset and hold force both grants low.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!rst && !hold) begin
      if (req_a && req_b) begin
        gnt_a = (last_q == REQ_B);
        gnt_b = (last_q == REQ_A);
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // Pointer moves only on a cycle that actually granted someone.
  always_comb begin
    last_d = last_q;
    if (gnt_a) begin
      last_d = REQ_A;
    end else if (gnt_b) begin
      last_d = REQ_B;
    end
  end

  // Pointer register; starts at B so A wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule : rr_arb2

// File: rtl/seg_disp_ctrl.sv
// Write-side controller for the quad seven-segment display: arbitrates two
// nibble writers, holds the four digit values and generates per-digit blink.
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int BLINK_DIV = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [1:0] idx_a,
  input  logic [3:0] dat_a,
  output logic       gnt_a,
  input  logic       req_b,
  input  logic [1:0] idx_b,
  input  logic [3:0] dat_b,
  output logic       gnt_b,
  input  logic       clr,
  input  logic       blink_wr,
  input  logic [3:0] blink_in,
  output logic [3:0] val0,
  output logic [3:0] val1,
  output logic [3:0] val2,
  output logic [3:0] val3,
  output logic [3:0] dig_on
);

  nibble_t                 val_q [NUM_DIGITS];
  nibble_t                 val_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   blink_mask_q;
  logic [NUM_DIGITS-1:0]   blink_mask_d;
  logic [BLINK_DIV-1:0]    cnt_q;
  logic [BLINK_DIV-1:0]    cnt_d;
  logic [NUM_DIGITS-1:0]   dig_on_q;
  logic [NUM_DIGITS-1:0]   dig_on_d;
  logic                    phase;

  // clr holds off both grants so a pending request survives the clear.
  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (req_a),
    .req_b (req_b),
    .hold  (clr),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign phase = cnt_q[BLINK_DIV-1];

  // Next digit values: clear wins, otherwise the granted writer commits.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      val_d[i] = val_q[i];
    end
    if (clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        val_d[i] = '0;
      end
    end else if (gnt_a) begin
      val_d[idx_a] = dat_a;
    end else if (gnt_b) begin
      val_d[idx_b] = dat_b;
    end
  end

  // Next blink state: mask load, free-running counter, lit-digit pattern.
  always_comb begin
    blink_mask_d = blink_wr ? blink_in : blink_mask_q;
    cnt_d        = cnt_q + BLINK_DIV'(1);
    dig_on_d     = digit_enables(blink_mask_q, phase);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the digit store is only four nibbles of flops, not a RAM, so it
      // is reset along with everything else to give a blank display.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        val_q[i] <= '0;
      end
      blink_mask_q <= '0;
      cnt_q        <= '0;
      dig_on_q     <= '1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        val_q[i] <= val_d[i];
      end
      blink_mask_q <= blink_mask_d;
      cnt_q        <= cnt_d;
      dig_on_q     <= dig_on_d;
    end
  end

  assign val0   = val_q[0];
  assign val1   = val_q[1];
  assign val2   = val_q[2];
  assign val3   = val_q[3];
  assign dig_on = dig_on_q;

endmodule : seg_disp_ctrl

// File: tb/tb_seg_disp_ctrl.sv
// Directed bench for seg_disp_ctrl with a 16-cycle blink period.
module tb_seg_disp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [1:0] idx_a, idx_b;
  logic [3:0] dat_a, dat_b;
  logic       gnt_a, gnt_b;
  logic       clr, blink_wr;
  logic [3:0] blink_in;
  logic [3:0] val0, val1, val2, val3;
  logic [3:0] dig_on;

  int passed = 0;
  int total  = 0;

  seg_disp_ctrl #(.BLINK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .idx_a    (idx_a),
    .dat_a    (dat_a),
    .gnt_a    (gnt_a),
    .req_b    (req_b),
    .idx_b    (idx_b),
    .dat_b    (dat_b),
    .gnt_b    (gnt_b),
    .clr      (clr),
    .blink_wr (blink_wr),
    .blink_in (blink_in),
    .val0     (val0),
    .val1     (val1),
    .val2     (val2),
    .val3     (val3),
    .dig_on   (dig_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_on;
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; idx_a = '0; idx_b = '0;
    dat_a = '0; dat_b = '0; clr = 1'b0; blink_wr = 1'b0; blink_in = '0;

    // Reset state
    #2;
    check("rst_val0", val0, 4'h0);
    check("rst_val1", val1, 4'h0);
    check("rst_val2", val2, 4'h0);
    check("rst_val3", val3, 4'h0);
    check("rst_dig_on", dig_on, 4'hF);
    check("rst_gnt_b", gnt_b, 1'b0);
    req_a = 1'b1;
    #1;
    check("rst_gnt_a_masked", gnt_a, 1'b0);
    req_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) tick();
    check("idle_dig_on", dig_on, 4'hF);

    // Single write from A
    req_a = 1'b1; idx_a = 2'd2; dat_a = 4'h7;
    #1;
    check("single_gnt_a", gnt_a, 1'b1);
    check("single_gnt_b", gnt_b, 1'b0);
    tick();
    req_a = 1'b0;
    check("single_val2", val2, 4'h7);
    check("single_val0", val0, 4'h0);
    check("single_val1", val1, 4'h0);
    check("single_val3", val3, 4'h0);

    // Fresh reset, then both requesters held high: alternate A, B, A, B
    rst = 1'b1;
    #1;
    check("rst2_val2", val2, 4'h0);
    #1;
    rst = 1'b0;
    req_a = 1'b1; idx_a = 2'd0; dat_a = 4'h1;
    req_b = 1'b1; idx_b = 2'd1; dat_b = 4'h2;
    #1;
    check("alt1_gnt_a", gnt_a, 1'b1);
    check("alt1_gnt_b", gnt_b, 1'b0);
    tick();
    check("alt2_gnt_a", gnt_a, 1'b0);
    check("alt2_gnt_b", gnt_b, 1'b1);
    check("alt2_val0", val0, 4'h1);
    tick();
    check("alt3_gnt_a", gnt_a, 1'b1);
    check("alt3_val1", val1, 4'h2);
    tick();
    check("alt4_gnt_b", gnt_b, 1'b1);
    tick();

    // Same digit on consecutive commits: later one wins
    idx_a = 2'd3; dat_a = 4'h5;
    idx_b = 2'd3; dat_b = 4'h9;
    #1;
    check("same_gnt_a", gnt_a, 1'b1);
    tick();
    check("same_val3_a", val3, 4'h5);
    check("same_gnt_b", gnt_b, 1'b1);
    tick();
    check("same_val3_b", val3, 4'h9);
    req_a = 1'b0; req_b = 1'b0;

    // clr suppresses grant, clears all, request survives
    req_b = 1'b1; idx_b = 2'd0; dat_b = 4'hC; clr = 1'b1;
    #1;
    check("clr_gnt_b", gnt_b, 1'b0);
    check("clr_gnt_a", gnt_a, 1'b0);
    tick();
    check("clr_val0", val0, 4'h0);
    check("clr_val1", val1, 4'h0);
    check("clr_val3", val3, 4'h0);
    clr = 1'b0;
    #1;
    check("post_clr_gnt_b", gnt_b, 1'b1);
    tick();
    req_b = 1'b0;
    check("post_clr_val0", val0, 4'hC);

    // Blink: reset to align cnt, then load mask 0101 before first edge
    rst = 1'b1;
    #1;
    rst = 1'b0;
    blink_wr = 1'b1; blink_in = 4'b0101;
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (k == 1) blink_wr = 1'b0;
      if (k == 2) begin
        req_b = 1'b1; idx_b = 2'd3; dat_b = 4'hB;
      end
      if (k == 3) req_b = 1'b0;
      // dig_on after edge k reflects cnt = k-1 and the mask loaded at edge 1
      exp_on = (k >= 2 && ((k - 1) % 16) >= 8) ? 4'hA : 4'hF;
      if (k <= 32 || k == 41) check($sformatf("blink_k%0d", k), dig_on, exp_on);
    end
    check("blink_val3", val3, 4'hB);

    // Reset during a pending request while blinking
    clr = 1'b1; req_a = 1'b1; idx_a = 2'd1; dat_a = 4'h6;
    #1;
    check("pend_gnt_a", gnt_a, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_dig_on", dig_on, 4'hF);
    check("mid_rst_val3", val3, 4'h0);
    check("mid_rst_gnt_a", gnt_a, 1'b0);
    rst = 1'b0; clr = 1'b0;
    #1;
    check("retry_gnt_a", gnt_a, 1'b1);
    tick();
    req_a = 1'b0;
    check("retry_val1", val1, 4'h6);
    for (int k = 0; k < 12; k++) begin
      tick();
      check($sformatf("mask_cleared_%0d", k), dig_on, 4'hF);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_seg_disp_ctrl
